// File: rtl/rs15_9_pkg.sv
// Shared constants and types for the RS(15,9) GF(16) encoder.
package rs15_9_pkg;

  localparam int WORD_WIDTH = 4;
  localparam int K_NUM      = 9;
  localparam int N_NUM      = 15;
  localparam int T2_NUM     = N_NUM - K_NUM;
  localparam int CNT_W      = 4;

  typedef logic [WORD_WIDTH-1:0] sym_t;
  typedef logic [CNT_W-1:0]      cnt_t;

  // g(x) = x^6 + 7x^5 + 9x^4 + 3x^3 + Cx^2 + Ax + C, index = power of x
  localparam sym_t G_COEF [0:T2_NUM-1] = '{4'hC, 4'hA, 4'hC, 4'h3, 4'h9, 4'h7};

  typedef enum logic {
    MSG = 1'b0,
    PAR = 1'b1
  } state_e;

endpackage

// File: rtl/rs15_9_encoder_if.sv
// Symbol stream bundle: message input stream and codeword output stream.
interface rs15_9_encoder_if;
  import rs15_9_pkg::*;

  logic s_valid;
  logic s_ready;
  sym_t s_data;
  logic m_valid;
  logic m_ready;
  sym_t m_data;
  logic m_sop;
  logic m_eop;

  // Upstream source / downstream sink side
  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_sop, m_eop
  );

  // Encoder side
  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_sop, m_eop
  );

endinterface

// File: rtl/gf2_3mult.sv
// Combinational GF(16) multiplier, field polynomial x^4+x+1.
module gf2_3mult
  import rs15_9_pkg::*;
(
  input  sym_t a_i,
  input  sym_t b_i,
  output sym_t p_o
);

  // Shift-and-add: a is multiplied by x each step and reduced by x^4 = x+1
  always_comb begin
    sym_t acc;
    sym_t sh;
    acc = '0;
    sh  = a_i;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      if (b_i[i]) acc = acc ^ sh;
      sh = {sh[WORD_WIDTH-2:0], 1'b0} ^ (sh[WORD_WIDTH-1] ? 4'h3 : 4'h0);
    end
    p_o = acc;
  end

endmodule

// File: rtl/gf2_add.sv
// GF(2^m) addition: plain XOR, no carries.
module gf2_add
  import rs15_9_pkg::*;
(
  input  sym_t a_i,
  input  sym_t b_i,
  output sym_t s_o
);

  assign s_o = a_i ^ b_i;

endmodule

// File: rtl/rs15_9_encoder.sv
// Systematic RS(15,9) encoder: echoes 9 message symbols, then shifts out
// 6 parity symbols from a GF(16) division LFSR. One output register stage.
module rs15_9_encoder
  import rs15_9_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  rs15_9_encoder_if.slave  bus
);

  state_e state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  sym_t   r_q [0:T2_NUM-1];
  sym_t   r_d [0:T2_NUM-1];
  logic   m_valid_q, m_valid_d;
  sym_t   m_data_q, m_data_d;
  logic   m_sop_q, m_sop_d;
  logic   m_eop_q, m_eop_d;

  logic   adv;
  logic   s_ready;
  logic   accept;
  sym_t   fb;
  sym_t   prod [0:T2_NUM-1];
  sym_t   sum  [1:T2_NUM-1];

  // The output register may load whenever it is empty or being drained
  assign adv     = ~m_valid_q | bus.m_ready;
  assign s_ready = adv & (state_q == MSG);
  assign accept  = bus.s_valid & s_ready;

  // Feedback term: incoming symbol plus the top LFSR stage
  gf2_add u_fb_add (
    .a_i (bus.s_data),
    .b_i (r_q[T2_NUM-1]),
    .s_o (fb)
  );

  genvar gi;
  generate
    for (gi = 0; gi < T2_NUM; gi++) begin : g_mult
      gf2_3mult u_mult (
        .a_i (fb),
        .b_i (G_COEF[gi]),
        .p_o (prod[gi])
      );
    end
    for (gi = 1; gi < T2_NUM; gi++) begin : g_add
      gf2_add u_add (
        .a_i (r_q[gi-1]),
        .b_i (prod[gi]),
        .s_o (sum[gi])
      );
    end
  endgenerate

  // State, counter, LFSR and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MSG;
      cnt_q     <= '0;
      r_q       <= '{default: '0};
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_sop_q   <= 1'b0;
      m_eop_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      r_q       <= r_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_sop_q   <= m_sop_d;
      m_eop_q   <= m_eop_d;
    end
  end

  // Phase sequencing: 9 accepted message symbols, then 6 parity shifts
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MSG: begin
        if (accept) begin
          if (cnt_q == cnt_t'(K_NUM - 1)) begin
            state_d = PAR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PAR: begin
        if (adv) begin
          if (cnt_q == cnt_t'(T2_NUM - 1)) begin
            state_d = MSG;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  // LFSR update and output register load for the current phase
  always_comb begin
    r_d       = r_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_sop_d   = m_sop_q;
    m_eop_d   = m_eop_q;
    unique case (state_q)
      MSG: begin
        if (accept) begin
          m_data_d  = bus.s_data;
          m_valid_d = 1'b1;
          m_sop_d   = (cnt_q == '0);
          m_eop_d   = 1'b0;
          r_d[0]    = prod[0];
          for (int i = 1; i < T2_NUM; i++) r_d[i] = sum[i];
        end else if (adv) begin
          m_valid_d = 1'b0;
        end
      end
      PAR: begin
        if (adv) begin
          m_data_d  = r_q[T2_NUM-1];
          m_valid_d = 1'b1;
          m_sop_d   = 1'b0;
          m_eop_d   = (cnt_q == cnt_t'(T2_NUM - 1));
          for (int i = 1; i < T2_NUM; i++) r_d[i] = r_q[i-1];
          r_d[0]    = '0;
        end
      end
    endcase
  end

  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_sop   = m_sop_q;
  assign bus.m_eop   = m_eop_q;

endmodule

// File: tb/tb_rs15_9_encoder.sv
// Self-checking bench for rs15_9_encoder against a polynomial-division model.
module tb_rs15_9_encoder;
  import rs15_9_pkg::*;

  typedef logic [14:0][3:0] cw_t;
  typedef logic [8:0][3:0]  msg_t;

  localparam int NCW_RAND  = 1000;
  localparam int NCW_STALL = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rs15_9_encoder_if bus_if ();

  rs15_9_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int checks   = 0;
  int failures = 0;

  logic [5:0] out_q [$];   // {sop, eop, data} per transferred symbol
  logic [3:0] sym_q [$];   // message symbols waiting to be offered
  logic [5:0] cont_out [0:NCW_STALL*15-1];
  msg_t       msgs [0:NCW_RAND-1];

  int         stall_viol = 0;
  int         stall_seen = 0;
  logic       held_v = 1'b0;
  logic [5:0] held;

  logic [3:0] exp_t [0:14];
  int         log_t [0:15];
  logic [3:0] gp [0:6];

  // Output monitor: records transfers and checks hold-under-stall
  always @(negedge clk) begin
    if (rst) begin
      held_v <= 1'b0;
    end else begin
      if (held_v && (!bus_if.m_valid ||
          {bus_if.m_sop, bus_if.m_eop, bus_if.m_data} !== held))
        stall_viol <= stall_viol + 1;
      if (bus_if.m_valid && bus_if.m_ready)
        out_q.push_back({bus_if.m_sop, bus_if.m_eop, bus_if.m_data});
      if (bus_if.m_valid && !bus_if.m_ready) begin
        held_v     <= 1'b1;
        held       <= {bus_if.m_sop, bus_if.m_eop, bus_if.m_data};
        stall_seen <= stall_seen + 1;
      end else begin
        held_v <= 1'b0;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // GF(16) via log/antilog tables built from powers of alpha = x
  task automatic init_field();
    logic [3:0] v;
    v = 4'h1;
    for (int i = 0; i < 15; i++) begin
      exp_t[i] = v;
      log_t[v] = i;
      v = {v[2:0], 1'b0} ^ (v[3] ? 4'h3 : 4'h0);
    end
    log_t[0] = 0;
  endtask

  function automatic logic [3:0] gmul(logic [3:0] a, logic [3:0] b);
    if (a == 4'h0 || b == 4'h0) return 4'h0;
    return exp_t[(log_t[a] + log_t[b]) % 15];
  endfunction

  // g(x) = prod (x + alpha^i), i = 1..6; gp[d] is the x^d coefficient
  task automatic init_gpoly();
    logic [3:0] nxt [0:6];
    for (int d = 0; d < 7; d++) gp[d] = 4'h0;
    gp[0] = 4'h1;
    for (int i = 1; i <= 6; i++) begin
      for (int d = 0; d < 7; d++)
        nxt[d] = gmul(exp_t[i], gp[d]) ^ ((d > 0) ? gp[d-1] : 4'h0);
      for (int d = 0; d < 7; d++) gp[d] = nxt[d];
    end
  endtask

  // Systematic codeword: message followed by remainder of m(x)*x^6 / g(x)
  function automatic cw_t ref_encode(msg_t m);
    cw_t c;
    logic [3:0] coef;
    c = '0;
    for (int j = 0; j < 9; j++) c[j] = m[j];
    for (int j = 0; j < 9; j++) begin
      coef = c[j];
      for (int k = 0; k < 7; k++) c[j+k] = c[j+k] ^ gmul(coef, gp[6-k]);
    end
    for (int j = 0; j < 9; j++) c[j] = m[j];
    return c;
  endfunction

  function automatic logic [3:0] syndrome(cw_t c, int i);
    logic [3:0] s;
    s = 4'h0;
    for (int j = 0; j < 15; j++) s = gmul(s, exp_t[i]) ^ c[j];
    return s;
  endfunction

  // Stimulus driver: offers queued symbols until n_out outputs are seen
  task automatic run_stream(input int n_out, input bit stall, output int cycles);
    int cyc;
    int budget;
    cyc    = 0;
    budget = n_out * 8 + 200;
    while (out_q.size() < n_out && cyc < budget) begin
      bus_if.s_valid = (sym_q.size() > 0) && (!stall || $urandom_range(0, 3) != 0);
      bus_if.s_data  = (sym_q.size() > 0) ? sym_q[0] : 4'h0;
      bus_if.m_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (bus_if.s_valid && bus_if.s_ready) void'(sym_q.pop_front());
      @(posedge clk);
      #1;
      cyc++;
    end
    bus_if.s_valid = 1'b0;
    bus_if.m_ready = 1'b1;
    cycles = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.s_valid = 1'b0;
    bus_if.s_data  = 4'h0;
    bus_if.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus_if.m_valid !== 1'b0) begin
      failures++; $display("FAIL reset_m_valid: got=%b exp=0", bus_if.m_valid);
    end
    checks++;
    if (bus_if.m_data !== 4'h0) begin
      failures++; $display("FAIL reset_m_data: got=%h exp=0", bus_if.m_data);
    end
    checks++;
    if ({bus_if.m_sop, bus_if.m_eop} !== 2'b00) begin
      failures++; $display("FAIL reset_sop_eop: got=%b exp=00", {bus_if.m_sop, bus_if.m_eop});
    end
    checks++;
    if (bus_if.s_ready !== 1'b1) begin
      failures++; $display("FAIL reset_s_ready: got=%b exp=1", bus_if.s_ready);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero();
    int cyc;
    out_q.delete();
    for (int j = 0; j < 9; j++) sym_q.push_back(4'h0);
    run_stream(15, 1'b0, cyc);
    checks++;
    if (out_q.size() != 15) begin
      failures++; $display("FAIL zero_count: got=%0d exp=15", out_q.size());
    end else begin
      for (int j = 0; j < 15; j++) begin
        checks++;
        if (out_q[j] !== {(j == 0), (j == 14), 4'h0}) begin
          failures++; $display("FAIL zero_sym%0d: got=%h exp=%h", j, out_q[j], {(j == 0), (j == 14), 4'h0});
        end
      end
    end
  endtask

  task automatic test_unit();
    int   cyc;
    cw_t  e;
    e = '0;
    e[8] = 4'h1;
    e[9] = 4'h7; e[10] = 4'h9; e[11] = 4'h3; e[12] = 4'hC; e[13] = 4'hA; e[14] = 4'hC;
    out_q.delete();
    for (int j = 0; j < 9; j++) sym_q.push_back(e[j]);
    run_stream(15, 1'b0, cyc);
    checks++;
    if (cyc != 16) begin
      failures++; $display("FAIL unit_latency: got=%0d cycles exp=16", cyc);
    end
    checks++;
    if (out_q.size() != 15) begin
      failures++; $display("FAIL unit_count: got=%0d exp=15", out_q.size());
    end else begin
      for (int j = 0; j < 15; j++) begin
        checks++;
        if (out_q[j] !== {(j == 0), (j == 14), e[j]}) begin
          failures++; $display("FAIL unit_sym%0d: got=%h exp=%h", j, out_q[j], {(j == 0), (j == 14), e[j]});
        end
      end
    end
  endtask

  task automatic test_alpha();
    int   cyc;
    cw_t  e;
    e = '0;
    e[8] = 4'h2;
    e[9] = 4'hE; e[10] = 4'h1; e[11] = 4'h6; e[12] = 4'hB; e[13] = 4'h7; e[14] = 4'hB;
    out_q.delete();
    for (int j = 0; j < 9; j++) sym_q.push_back(e[j]);
    run_stream(15, 1'b0, cyc);
    checks++;
    if (out_q.size() != 15) begin
      failures++; $display("FAIL alpha_count: got=%0d exp=15", out_q.size());
    end else begin
      for (int j = 9; j < 15; j++) begin
        checks++;
        if (out_q[j][3:0] !== e[j]) begin
          failures++; $display("FAIL alpha_par%0d: got=%h exp=%h", j - 9, out_q[j][3:0], e[j]);
        end
      end
    end
  endtask

  task automatic test_random();
    int   cyc;
    cw_t  got;
    cw_t  exp_cw;
    logic [14:0] fl;
    logic [5:0]  syn;
    out_q.delete();
    for (int c = 0; c < NCW_RAND; c++) begin
      for (int j = 0; j < 9; j++) begin
        msgs[c][j] = 4'($urandom_range(0, 15));
        sym_q.push_back(msgs[c][j]);
      end
    end
    run_stream(NCW_RAND * 15, 1'b0, cyc);
    checks++;
    if (cyc != NCW_RAND * 15 + 1) begin
      failures++; $display("FAIL rand_no_bubbles: got=%0d cycles exp=%0d", cyc, NCW_RAND * 15 + 1);
    end
    checks++;
    if (out_q.size() != NCW_RAND * 15) begin
      failures++; $display("FAIL rand_count: got=%0d exp=%0d", out_q.size(), NCW_RAND * 15);
    end else begin
      for (int i = 0; i < NCW_STALL * 15; i++) cont_out[i] = out_q[i];
      for (int c = 0; c < NCW_RAND; c++) begin
        for (int j = 0; j < 15; j++) begin
          got[j] = out_q[c*15 + j][3:0];
          fl[j]  = out_q[c*15 + j][5] ^ (j == 0) | out_q[c*15 + j][4] ^ (j == 14);
        end
        exp_cw = ref_encode(msgs[c]);
        for (int i = 1; i <= 6; i++) syn[i-1] = |syndrome(got, i);
        checks++;
        if (got !== exp_cw) begin
          failures++; $display("FAIL rand_cw%0d: got=%h exp=%h", c, got, exp_cw);
        end
        checks++;
        if (syn !== 6'b0) begin
          failures++; $display("FAIL rand_syn%0d: nonzero syndrome mask got=%b exp=000000", c, syn);
        end
        checks++;
        if (fl !== 15'b0) begin
          failures++; $display("FAIL rand_flags%0d: flag error mask got=%b exp=0", c, fl);
        end
      end
    end
  endtask

  task automatic test_stall();
    int cyc;
    int v0;
    int s0;
    logic [89:0] got;
    logic [89:0] exp_v;
    v0 = stall_viol;
    s0 = stall_seen;
    out_q.delete();
    for (int c = 0; c < NCW_STALL; c++)
      for (int j = 0; j < 9; j++) sym_q.push_back(msgs[c][j]);
    run_stream(NCW_STALL * 15, 1'b1, cyc);
    checks++;
    if (out_q.size() != NCW_STALL * 15) begin
      failures++; $display("FAIL stall_count: got=%0d exp=%0d", out_q.size(), NCW_STALL * 15);
    end else begin
      for (int c = 0; c < NCW_STALL; c++) begin
        for (int j = 0; j < 15; j++) begin
          got[j*6 +: 6]   = out_q[c*15 + j];
          exp_v[j*6 +: 6] = cont_out[c*15 + j];
        end
        checks++;
        if (got !== exp_v) begin
          failures++; $display("FAIL stall_cw%0d: got=%h exp=%h", c, got, exp_v);
        end
      end
    end
    checks++;
    if (stall_viol != v0) begin
      failures++; $display("FAIL stall_hold: got=%0d unstable cycles exp=0", stall_viol - v0);
    end
    checks++;
    if (stall_seen <= s0) begin
      failures++; $display("FAIL stall_seen: got=%0d stalled cycles exp>0", stall_seen - s0);
    end
  endtask

  task automatic test_reset_mid();
    int         cyc;
    logic [3:0] first;
    cw_t        e;
    first = 4'($urandom_range(1, 15));
    for (int i = 0; i < 5; i++) begin
      bus_if.s_valid = 1'b1;
      bus_if.s_data  = (i == 0) ? first : 4'($urandom_range(0, 15));
      bus_if.m_ready = 1'b1;
      @(negedge clk);
      if (i == 1) begin
        checks++;
        if ({bus_if.m_valid, bus_if.m_sop, bus_if.m_data} !== {2'b11, first}) begin
          failures++;
          $display("FAIL latency_first: got v/sop/data=%b/%b/%h exp=1/1/%h",
                   bus_if.m_valid, bus_if.m_sop, bus_if.m_data, first);
        end
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    bus_if.s_valid = 1'b1;
    bus_if.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus_if.m_valid, bus_if.m_data} !== 5'b0) begin
      failures++; $display("FAIL midrst_out: got v/data=%b/%h exp=0/0", bus_if.m_valid, bus_if.m_data);
    end
    rst = 1'b0;
    bus_if.s_valid = 1'b0;
    bus_if.m_ready = 1'b1;
    out_q.delete();
    sym_q.delete();
    e = '0;
    e[8] = 4'h1;
    e[9] = 4'h7; e[10] = 4'h9; e[11] = 4'h3; e[12] = 4'hC; e[13] = 4'hA; e[14] = 4'hC;
    for (int j = 0; j < 9; j++) sym_q.push_back(e[j]);
    run_stream(15, 1'b0, cyc);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (out_q.size() != 15 || cyc != 16) begin
      failures++; $display("FAIL midrst_count: got=%0d syms in %0d cycles exp=15 in 16", out_q.size(), cyc);
    end else begin
      for (int j = 0; j < 15; j++) begin
        checks++;
        if (out_q[j] !== {(j == 0), (j == 14), e[j]}) begin
          failures++; $display("FAIL midrst_sym%0d: got=%h exp=%h", j, out_q[j], {(j == 0), (j == 14), e[j]});
        end
      end
    end
  endtask

  initial begin
    bus_if.s_valid = 1'b0;
    bus_if.s_data  = 4'h0;
    bus_if.m_ready = 1'b1;
    init_field();
    init_gpoly();
    test_reset();
    test_zero();
    test_unit();
    test_alpha();
    test_random();
    test_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rs15_9_encoder.md
Name: rs15_9_encoder

Overview:
- Systematic RS(15,9) encoder over GF(16), primitive polynomial x^4+x+1, t=3. It is the transmit-side counterpart of the decoder chain (syndrome, key equation, Chien, Forney).
- Accepts 9 message symbols per codeword on a valid/ready stream.
- Re-emits the 9 message symbols unchanged, then appends 6 parity symbols computed by a 6-stage GF(16) LFSR.
- Output stream uses valid/ready with full backpressure and single-register output buffering.

Parameters:
- WORD_WIDTH, 4, symbol width; only legal value.
- K_NUM, 9, message symbols per codeword; only legal value.
- N_NUM, 15, codeword symbols; only legal value.
- T2_NUM, N_NUM-K_NUM = 6, parity symbols and LFSR depth.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input symbol valid.
- s_ready  out  1  encoder can accept an input symbol.
- s_data  in  4  message symbol; the first symbol is the highest-degree coefficient (x^14).
- m_valid  out  1  output symbol valid.
- m_ready  in  1  downstream accepts the output symbol.
- m_data  out  4  codeword symbol, highest degree first.
- m_sop  out  1  marks codeword symbol 0; valid only with m_valid.
- m_eop  out  1  marks codeword symbol 14 (last parity); valid only with m_valid.

Behaviour:
- Generator polynomial: g(x) = prod_{i=1..6}(x+alpha^i) = x^6 + 7x^5 + 9x^4 + 3x^3 + Cx^2 + Ax + C (hex coefficients).
  - g5..g0 = 7, 9, 3, C, A, C.
- Reset (rst=1 at a clock edge): state=MSG, cnt=0, r[0..5]=0, m_valid=0, m_data=0, m_sop=0, m_eop=0. rst overrides every other input, including mid-codeword; any partial codeword is discarded.
- Advance condition: adv = ~m_valid | m_ready. The output register loads only when adv=1; otherwise it holds m_data, m_sop and m_eop stable.
- s_ready = adv & (state==MSG). It is combinational from m_valid/m_ready and does not depend on s_valid.
- State MSG (cnt 0..8):
  - On accept (s_valid & s_ready): m_data<=s_data, m_valid<=1, m_sop<=(cnt==0), m_eop<=0.
  - LFSR update on accept, with f = s_data ^ r[5]:
    - r[0] <= g0·f
    - r[i] <= r[i-1] ^ gi·f, for i=1..5
  - cnt increments on accept.
  - On the accept at cnt==8: state<=PAR, cnt<=0.
  - adv=1 with no accept: m_valid<=0.
- State PAR (cnt 0..5), s_ready=0:
  - On adv: m_data<=r[5], m_valid<=1, m_sop<=0, m_eop<=(cnt==5).
  - Shift r[i]<=r[i-1], r[0]<=0.
  - cnt increments.
  - On the adv at cnt==5: state<=MSG, cnt<=0. The LFSR is all-zero at this point by construction.
- Latency: an input symbol appears on m_data one cycle after acceptance.
- Parity p5 appears in the cycle after the 9th accept, provided m_ready=1.
- Sustained throughput with m_ready=1 and s_valid=1: one codeword per 15 cycles, no bubbles. s_ready is low for 6 cycles per codeword.
- Backpressure (m_ready=0 with m_valid=1): all state, LFSR and output are frozen; s_ready=0.
- s_valid may deassert mid-message. The encoder waits in MSG with cnt and LFSR held; m_valid drops once the held symbol is taken.
- GF arithmetic:
  - Addition is 4-bit XOR.
  - Constant multiplies use the GF(16) multiplier modulo x^4+x+1.
  - No carries, no width growth.

Decomposition:
- Shared package rs15_9_pkg holds:
  - WORD_WIDTH, K_NUM, N_NUM, T2_NUM.
  - Generator coefficient constant array G_COEF[0:5] = {C,A,C,3,9,7}.
  - State enum {MSG, PAR}.
- Reuse the codebase GF(16) multiplier gf2_3mult with one operand tied to G_COEF[i]; six instances.
- Reuse gf2_add for the XOR terms.
- No new sub-module is required.

Test Plan:
- All-zero message (9 × 0), m_ready=1 -> 15 output symbols all 0; m_sop on symbol 0, m_eop on symbol 14.
- Message 0,0,0,0,0,0,0,0,1 -> message echoed, then parity 7,9,3,C,A,C.
- Message 0,...,0,2 -> parity E,1,6,B,7,B (linearity check against the previous case scaled by alpha).
- Random messages, 1000 codewords, continuous valid/ready -> every codeword has zero syndromes S1..S6 against a reference model, and there are no idle cycles.
- Random m_ready toggling and s_valid gaps -> identical output sequence to the no-stall run, and m_data/m_sop/m_eop stable while m_valid & ~m_ready.
- rst asserted at symbol 5 of message, then a clean message 0,...,0,1 -> no stale output after reset, correct parity 7,9,3,C,A,C.
